im_loader: RTL and testbench
============================

# im_loader

Program loader that sits directly upstream of the processor's instruction memory. It accepts a byte stream over a valid/ready handshake, parses a length header, assembles big-endian 16-bit instruction words, writes them to consecutive IM addresses from 0, and verifies an XOR checksum. On success it releases the processor from hold and pulses `cpu_start`. On failure it keeps the processor held and flags an error.

## Interface
- `ADDR_W`, default 10: IM address width; maximum program length is 2^ADDR_W words.
- `DATA_W`, default 16: instruction width. Fixed at 16; the byte assembly depends on it.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  one clock; reset is asynchronous and active-low (`reset` low clears all state).
- `load_req`  in  1  one-cycle request to begin or restart a load.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `im_en_write`  out  1  IM write strobe.
- `im_address`  out  ADDR_W  IM write address.
- `im_data_in`  out  16  IM write data.
- `cpu_hold`  out  1  active-high hold/reset to the processor.
- `cpu_start`  out  1  one-cycle start pulse to the control unit.
- `done`  out  1  program loaded and verified (level).
- `error`  out  1  bad length or checksum mismatch (level).
- `words_loaded`  out  ADDR_W+1  count of words written in the current load.

## Operation
- A byte is accepted on a rising edge where `in_valid & in_ready`. No byte is consumed in any other cycle.
- Stream format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N pairs of HI, LO bytes, one pair per instruction.
  - One CHK byte.
- Checksum rule: the XOR of every byte in the stream, including CHK, must equal 8'h00.
- FSM states: IDLE, LEN_HI, LEN_LO, W_HI, W_LO, WRITE, CHK, RUN, ERROR.
- IDLE: `in_ready`=0. `load_req` moves to LEN_HI and clears `words_loaded`, the address counter, the running XOR and `error`.
- LEN_HI: `in_ready`=1; on accept, latch the byte into len[15:8] and go to LEN_LO.
- LEN_LO: `in_ready`=1; on accept, latch len[7:0].
  - If N==0 or N>2^ADDR_W, go to ERROR.
  - Otherwise go to W_HI.
- W_HI: `in_ready`=1; on accept, latch word[15:8] and go to W_LO.
- W_LO: `in_ready`=1; on accept, latch word[7:0] and go to WRITE.
- WRITE: `in_ready`=0. `im_en_write`=1 with `im_address`=address counter and `im_data_in`=word, for exactly one cycle. Then increment the address counter and `words_loaded`.
  - If `words_loaded`+1==N, go to CHK.
  - Otherwise go to W_HI.
- CHK: `in_ready`=1; on accept, fold the byte into the XOR.
  - If the result is 0, go to RUN.
  - Otherwise go to ERROR.
- RUN: `done`=1, `cpu_hold`=0, `in_ready`=0.
- ERROR: `error`=1, `cpu_hold`=1, `in_ready`=0.
- The running XOR covers all accepted bytes, including the length bytes.
- `load_req` is honoured only in IDLE, RUN and ERROR. In any other state it is ignored.
- `load_req` in RUN or ERROR: go to LEN_HI with the same clears as from IDLE, and deassert `done` and `error`.
- `in_valid` may be low for any number of cycles in an accepting state; the FSM waits.
- `im_address` wraps naturally. It never needs to, because N ≤ 2^ADDR_W is enforced.

## Timing
- Reset values of all outputs:
  - state IDLE;
  - `in_ready`=0, `im_en_write`=0, `im_address`=0, `im_data_in`=0;
  - `cpu_hold`=1, `cpu_start`=0, `done`=0, `error`=0, `words_loaded`=0.
- Reset behaviour:
  - Assertion takes effect asynchronously at any point, including mid-load; a partial program is abandoned.
  - Deassertion is sampled synchronously on `clk`.
- All outputs are registered or decoded from registered state; `in_ready` has no combinational path from `in_valid`.
- Throughput: 3 cycles per word at full rate (W_HI, W_LO, WRITE).
- A full-rate load takes 2 + 3N + 1 cycles from the first LEN_HI accept to the RUN entry.
- On entry to RUN:
  - `cpu_start`=1 for exactly the first RUN cycle;
  - `cpu_hold` falls and `done` rises in that same cycle;
  - `cpu_start` is not repeated while the FSM stays in RUN.
- `cpu_hold` re-asserts in the cycle after a `load_req` accepted in RUN.
- `im_en_write` is never high outside WRITE.

## Test plan
- Normal load, N=2, words 16'h4004 and 16'h7000: stream 00 02 40 04 70 00 CHK=0x36 at full rate.
  - Expect exactly two IM writes: addr0=4004, addr1=7000.
  - Expect `done`=1, a one-cycle `cpu_start`, and `cpu_hold`=0 after 10 cycles.
- Bad checksum: same stream with CHK=0x37.
  - Expect `error`=1, `cpu_hold`=1, no `cpu_start`, and `words_loaded`=2.
- Length errors:
  - N=0: stream 00 00 goes to ERROR with no IM write.
  - N=0x0401 with ADDR_W=10 goes to ERROR.
  - N=0x0400 is accepted.
- Back-pressure and gaps: toggle `in_valid` randomly during the normal-load stream.
  - Expect identical IM contents.
  - Expect no byte accepted while `in_ready`=0 in WRITE.
- Reset mid-load: assert `reset` low after the first word is written, then reload a 1-word program.
  - Expect all outputs at reset values immediately.
  - Expect the reload to write addr0 and reach RUN.
- Reload from RUN: after a successful load, pulse `load_req`.
  - Expect `done`=0 and `cpu_hold`=1 the next cycle.
  - Expect a `load_req` arriving during W_HI to be ignored.

Source files
------------

// File: rtl/im_loader.sv
// Byte-stream program loader for the instruction memory: length header, big-endian
// 16-bit words, XOR checksum, then release of the processor from hold.
module im_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_en_write,
    output logic [ADDR_W-1:0] im_address,
    output logic [DATA_W-1:0] im_data_in,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, W_HI, W_LO, WRITE, CHK, RUN, ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_A = 1;
    localparam logic [ADDR_W:0]   ONE_W = 1;

    state_t            state, state_n;
    logic [15:0]       len;
    logic [15:0]       len_n;
    logic [7:0]        xsum;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;
    logic              start_q;
    logic              accept, load, len_bad, last_word;

    assign accept    = in_valid & in_ready;
    assign load      = load_req & (state == IDLE || state == RUN || state == ERROR);
    // Low length byte is still on the bus while LEN_LO decides, so test the assembled value.
    assign len_n     = {len[15:8], in_data};
    assign len_bad   = (len_n == 16'd0) || (32'(len_n) > (32'd1 << ADDR_W));
    assign last_word = (32'(words_loaded) + 32'd1) == 32'(len);

    assign in_ready    = (state == LEN_HI) || (state == LEN_LO) || (state == W_HI) ||
                         (state == W_LO)   || (state == CHK);
    assign im_en_write = (state == WRITE);
    assign im_address  = addr;
    assign im_data_in  = word;
    assign cpu_hold    = (state != RUN);
    assign done        = (state == RUN);
    assign error       = (state == ERROR);
    assign cpu_start   = start_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_n;
            start_q <= (state == CHK) && (state_n == RUN);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (load_req) state_n = LEN_HI;
            LEN_HI: if (accept) state_n = LEN_LO;
            LEN_LO: if (accept) state_n = len_bad ? ERROR : W_HI;
            W_HI:   if (accept) state_n = W_LO;
            W_LO:   if (accept) state_n = WRITE;
            WRITE:  state_n = last_word ? CHK : W_HI;
            CHK:    if (accept) state_n = ((xsum ^ in_data) == 8'h00) ? RUN : ERROR;
            RUN, ERROR: if (load_req) state_n = LEN_HI;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len          <= '0;
            xsum         <= '0;
            addr         <= '0;
            word         <= '0;
            words_loaded <= '0;
        end else begin
            // load and accept are exclusive: load only fires in non-accepting states
            if (load) begin
                xsum         <= '0;
                addr         <= '0;
                words_loaded <= '0;
            end else if (accept) begin
                xsum <= xsum ^ in_data;
            end
            if (accept) begin
                case (state)
                    LEN_HI:  len[15:8]  <= in_data;
                    LEN_LO:  len[7:0]   <= in_data;
                    W_HI:    word[15:8] <= in_data;
                    W_LO:    word[7:0]  <= in_data;
                    default: ;
                endcase
            end
            if (state == WRITE) begin
                addr         <= addr + ONE_A;
                words_loaded <= words_loaded + ONE_W;
            end
        end
    end
endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader: streams are parsed by a stream-level reference model
// and the observed IM writes, status levels and start pulses are compared against it.
module tb_im_loader;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_req = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready, im_en_write, cpu_hold, cpu_start, done, error;
    logic [AW-1:0] im_address;
    logic [15:0]   im_data_in;
    logic [AW:0]   words_loaded;

    im_loader #(.ADDR_W(AW), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .im_en_write(im_en_write),
        .im_address(im_address), .im_data_in(im_data_in), .cpu_hold(cpu_hold),
        .cpu_start(cpu_start), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int starts, start_bad, bad_ready, rise_cyc, load_edge;
    logic done_prev = 1'b0;
    logic [7:0] stream[$];
    logic [AW+15:0] wr_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe writes and start pulses away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            if (im_en_write) begin
                wr_q.push_back({im_address, im_data_in});
                if (in_ready) bad_ready++;
            end
            if (cpu_start) begin
                starts++;
                if (!(done && !done_prev)) start_bad++;
            end
            if (done && !done_prev) rise_cyc = cyc;
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 0);
        chk({tag, ".im_en_write"}, 32'(im_en_write), 0);
        chk({tag, ".im_address"}, 32'(im_address), 0);
        chk({tag, ".im_data_in"}, 32'(im_data_in), 0);
        chk({tag, ".cpu_hold"}, 32'(cpu_hold), 1);
        chk({tag, ".cpu_start"}, 32'(cpu_start), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".error"}, 32'(error), 0);
        chk({tag, ".words_loaded"}, 32'(words_loaded), 0);
    endtask

    // Random program of n words; corrupt flips the checksum byte.
    task automatic build(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) stream.push_back(8'($urandom));
        x = 8'h00;
        foreach (stream[i]) x = x ^ stream[i];
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        b = x;
        stream.push_back(b);
    endtask

    task automatic run_load(input int gap_pct, input bit spurious, input bit abort, input bit no_req);
        int idx = 0;
        int guard = 0;
        bit rdy;
        bit sent = 0;
        wr_q.delete();
        starts = 0; start_bad = 0; bad_ready = 0; rise_cyc = -1;
        if (!no_req) begin
            load_req = 1'b1;
            @(posedge clk); #1;
            load_req = 1'b0;
        end
        load_edge = cyc;
        while (idx < stream.size() && guard < 30000 && !(abort && wr_q.size() > 0)) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = stream[idx];
            if (spurious && idx == 2 && !sent) begin
                load_req = 1'b1;
                sent = 1;
            end
            @(negedge clk); rdy = in_ready;
            @(posedge clk); if (in_valid && rdy) idx++;
            #1;
            load_req = 1'b0;
            guard++;
        end
        in_valid = 1'b0;
        chk("feed_complete", 32'((idx == stream.size()) || abort), 1);
        if (!abort) begin
            guard = 0;
            while (!(done || error) && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            chk("terminal_reached", 32'(done || error), 1);
            repeat (4) @(negedge clk);
            @(posedge clk); #1;
        end
    endtask

    // Reference: parse the stream by its rules and compare the whole outcome.
    task automatic verify(input string tag);
        int n;
        bit len_bad, exp_err;
        logic [7:0] x;
        int mism = 0;
        logic [15:0] w;
        n = {stream[0], stream[1]};
        len_bad = (n == 0) || (n > (1 << AW));
        x = 8'h00;
        foreach (stream[i]) x = x ^ stream[i];
        exp_err = len_bad || (x != 8'h00);
        chk({tag, ".done"}, 32'(done), 32'(!exp_err));
        chk({tag, ".error"}, 32'(error), 32'(exp_err));
        chk({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(exp_err));
        chk({tag, ".starts"}, 32'(starts), exp_err ? 0 : 1);
        chk({tag, ".start_align"}, 32'(start_bad), 0);
        chk({tag, ".words_loaded"}, 32'(words_loaded), len_bad ? 0 : 32'(n));
        chk({tag, ".n_writes"}, 32'(wr_q.size()), len_bad ? 0 : 32'(n));
        chk({tag, ".ready_in_write"}, 32'(bad_ready), 0);
        if (!len_bad) begin
            for (int i = 0; i < n && i < wr_q.size(); i++) begin
                w = {stream[2 + 2 * i], stream[3 + 2 * i]};
                if (wr_q[i] !== {AW'(i), w}) mism++;
            end
        end
        chk({tag, ".write_content"}, 32'(mism), 0);
    endtask

    initial begin
        // Reset state, held low across an edge.
        #2;
        check_reset_vals("reset");
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", 32'(in_ready), 0);

        // Normal N=2 load at full rate, plus latency from the load_req edge to RUN.
        stream = {8'h00, 8'h02, 8'h40, 8'h04, 8'h70, 8'h00, 8'h36};
        run_load(0, 0, 0, 0);
        verify("normal");
        chk("normal.latency", 32'(rise_cyc - load_edge), 9);

        // Bad checksum from RUN.
        stream = {8'h00, 8'h02, 8'h40, 8'h04, 8'h70, 8'h00, 8'h37};
        run_load(0, 0, 0, 0);
        verify("bad_chk");

        // Length errors.
        stream = {8'h00, 8'h00};
        run_load(0, 0, 0, 0);
        verify("len_zero");
        stream = {8'h04, 8'h01};
        run_load(0, 0, 0, 0);
        verify("len_over");

        // Maximum length is accepted.
        build(1 << AW, 0);
        run_load(0, 0, 0, 0);
        verify("len_max");

        // Back-pressure on the reference stream.
        stream = {8'h00, 8'h02, 8'h40, 8'h04, 8'h70, 8'h00, 8'h36};
        run_load(50, 0, 0, 0);
        verify("gaps");

        // Random programs, some with corrupted checksums.
        for (int k = 0; k < 6; k++) begin
            build($urandom_range(1, 12), $urandom_range(0, 2) == 0);
            run_load($urandom_range(0, 60), 0, 0, 0);
            verify($sformatf("rand%0d", k));
        end

        // Reset mid-load after the first word lands.
        build(3, 0);
        run_load(20, 0, 1, 0);
        chk("abort.one_write", 32'(wr_q.size()), 1);
        #2 reset = 1'b0;
        #1 check_reset_vals("midreset");
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        build(1, 0);
        run_load(30, 0, 0, 0);
        verify("rst_reload");

        // Reload from RUN, with a load_req during W_HI that must be ignored.
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        chk("reload.done", 32'(done), 0);
        chk("reload.cpu_hold", 32'(cpu_hold), 1);
        chk("reload.in_ready", 32'(in_ready), 1);
        build(4, 0);
        run_load(20, 1, 0, 1);
        verify("reload");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
